seq_divider4: RTL



---
 rtl/seq_divider4.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_divider4.sv
// seq_divider4: iterative 4-bit unsigned restoring divider.
// One quotient bit per cycle, decided by the 4-bit parallel subtractor.
// A start/busy/done handshake returns quotient, remainder and a
// divide-by-zero flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one restoring iteration per cycle, four in total
// DONE  | single-cycle done pulse; results already loaded

// 4-bit ripple subtractor: diff = a - b - borrowIn, borrowOut on underflow.
module parallel_sub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       borrowIn,
   output logic [3:0] diff,
   output logic       borrowOut
);

   logic [4:0] w_borrow;

   // Bit-serial borrow chain, one full-subtractor cell per bit
   always_comb begin
      w_borrow    = '0;
      w_borrow[0] = borrowIn;
      diff        = '0;
      for (int i = 0; i < 4; i++) begin
         diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
         w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
      end
      borrowOut = w_borrow[4];
   end

endmodule

module seq_divider4 (
   input  logic       clk,
   input  logic       rstN,
   input  logic       start,
   input  logic [3:0] dividend,
   input  logic [3:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [3:0] quotient,
   output logic [3:0] remainder,
   output logic       divByZero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] r_state;
   logic [3:0] r_rem;
   logic [3:0] r_q;
   logic [3:0] r_d;
   logic [1:0] r_cnt;
   logic       r_busy;
   logic       r_done;
   logic [3:0] r_quotient;
   logic [3:0] r_remainder;
   logic       r_div_by_zero;

   logic [4:0] w_shift;
   logic [3:0] w_diff;
   logic       w_borrow;
   logic       w_trial_ok;
   logic [3:0] w_rem_next;
   logic [3:0] w_q_next;

   // Shift in the next dividend bit; a set MSB means the trial always fits
   // and the subtractor's 4-bit diff is still the exact remainder.
   assign w_shift = {r_rem, r_q[3]};

   parallel_sub u_sub (
      .a         (w_shift[3:0]),
      .b         (r_d),
      .borrowIn  (1'b0),
      .diff      (w_diff),
      .borrowOut (w_borrow)
   );

   assign w_trial_ok = w_shift[4] | ~w_borrow;
   assign w_rem_next = w_trial_ok ? w_diff : w_shift[3:0];
   assign w_q_next   = {r_q[2:0], w_trial_ok};

   // Control FSM, working registers and result registers
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state       <= IDLE;
         r_rem         <= '0;
         r_q           <= '0;
         r_d           <= '0;
         r_cnt         <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_q   <= dividend;
                  r_d   <= divisor;
                  r_rem <= '0;
                  r_cnt <= 2'd3;
                  if (divisor != 4'd0) begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     // Zero divisor skips the iterations entirely
                     r_state       <= DONE;
                     r_done        <= 1'b1;
                     r_quotient    <= 4'hF;
                     r_remainder   <= dividend;
                     r_div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_rem <= w_rem_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt - 2'd1;
               if (r_cnt == 2'd0) begin
                  r_state       <= DONE;
                  r_busy        <= 1'b0;
                  r_done        <= 1'b1;
                  r_quotient    <= w_q_next;
                  r_remainder   <= w_rem_next;
                  r_div_by_zero <= 1'b0;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign divByZero = r_div_by_zero;

endmodule
